// File: rtl/mor1kx_dbus_bridge_wb_pkg.sv
// -----------------------------------------------------------------------------
// mor1kx_dbus_bridge_wb_pkg
//   Shared definitions for the LSU data-bus to Wishbone B3 bridge: bridge
//   state encoding and the fixed Wishbone cycle-type / burst-type codes
//   driven on every (single-beat, classic) access.
//   No ports; imported by the bridge top.
// -----------------------------------------------------------------------------
package mor1kx_dbus_bridge_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } bridge_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/mor1kx_dbus_bridge_wb_if.sv
// -----------------------------------------------------------------------------
// mor1kx_dbus_bridge_wb_if
//   Wishbone B3 master-side bundle between the dbus bridge and the system
//   interconnect.
//   master modport (bridge): drives wbm_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/
//                            cti_o/bte_o, samples wbm_dat_i/ack_i/err_i/rty_i.
//   slave modport (fabric):  the mirror image.
// -----------------------------------------------------------------------------
interface mor1kx_dbus_bridge_wb_if #(
    parameter int OW = 32
);
    logic [OW-1:0] wbm_adr_o;
    logic [OW-1:0] wbm_dat_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_we_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic [2:0]    wbm_cti_o;
    logic [1:0]    wbm_bte_o;
    logic [OW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;
    logic          wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
               wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
               wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/mor1kx_bus_timeout.sv
// -----------------------------------------------------------------------------
// mor1kx_bus_timeout
//   Down-counter bounding how long one bus phase may wait for a response.
//   clr loads TIMEOUT_CYCLES-1, en decrements (saturating at zero), and
//   expired is high while the count is zero, i.e. during the
//   TIMEOUT_CYCLES-th enabled cycle after a clear.
//   TIMEOUT_CYCLES = 0 removes the counter; expired is tied low.
//   Ports: clk, rst (sync, active-high), clr, en -> expired.
// -----------------------------------------------------------------------------
module mor1kx_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
            wire unused_inputs = &{1'b0, clk, rst, clr, en};
        end else begin : g_counter
            localparam int            W    = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [W-1:0]  LOAD = W'(TIMEOUT_CYCLES - 1);

            logic [W-1:0] count_q;

            // NOTE: clocked state uses non-blocking assignments so every
            // register samples its inputs from before the edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else if (clr) begin
                    count_q <= LOAD;
                end else if (en && (count_q != '0)) begin
                    count_q <= count_q - W'(1);
                end
            end

            assign expired = (count_q == '0);
        end
    endgenerate

endmodule

// File: rtl/mor1kx_dbus_bridge_wb.sv
// -----------------------------------------------------------------------------
// mor1kx_dbus_bridge_wb
//   Turns the espresso LSU's request/ack data-bus protocol into Wishbone B3
//   classic single cycles. All bus-facing outputs are registered. Slave
//   error, retry exhaustion and timeout all finish the access as a one-cycle
//   cpu_err_o pulse, so the CPU never waits unboundedly.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     cpu_req_i..cpu_we_i request from the LSU (held until ack/err)
//     cpu_burst_i         not used: every access is a single beat
//     cpu_ack_o/err_o     one-cycle completion / error pulse
//     cpu_dat_o           load data, valid with cpu_ack_o, held otherwise
//     wbm                 Wishbone master bundle
// -----------------------------------------------------------------------------
module mor1kx_dbus_bridge_wb
    import mor1kx_dbus_bridge_wb_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int RETRY_LIMIT          = 3,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_dat_i,
    input  logic [3:0]                      cpu_bsel_i,
    input  logic                            cpu_we_i,
    input  logic                            cpu_burst_i,
    output logic                            cpu_ack_o,
    output logic                            cpu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] cpu_dat_o,
    mor1kx_dbus_bridge_wb_if.master         wbm
);

    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

    // Bursts are not supported; the hint is accepted and dropped.
    wire unused_burst = cpu_burst_i;

    bridge_state_t state_q, state_d;
    logic [OW-1:0] adr_q, adr_d;
    logic [OW-1:0] wdat_q, wdat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [OW-1:0] rdat_q, rdat_d;
    logic [RW-1:0] retry_q, retry_d;

    logic to_clr;
    logic to_en;
    logic to_expired;

    mor1kx_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case leaves it unassigned and infers a latch.
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
        retry_d = retry_q;
        to_clr  = 1'b0;
        to_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    // Fields are frozen here and stay put for the whole
                    // access, including retries.
                    adr_d   = cpu_adr_i;
                    wdat_d  = cpu_dat_i;
                    sel_d   = cpu_bsel_i;
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    retry_d = '0;
                    to_clr  = 1'b1;
                    state_d = BUS;
                end
            end

            BUS: begin
                to_en = 1'b1;
                // Priority: err > ack > rty > timeout.
                if (wbm.wbm_err_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (wbm.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    if (!we_q) begin
                        rdat_d = wbm.wbm_dat_i;
                    end
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (wbm.wbm_rty_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end else if (to_expired) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end

            BACKOFF: begin
                // One idle cycle with cyc low, then retry the same access
                // with a fresh timeout window; the retry count is kept.
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                to_clr  = 1'b1;
                state_d = BUS;
            end

            RESP: begin
                // The response pulse is visible this cycle; a still-high
                // request is deliberately not looked at until IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_ack_o = ack_q;
    assign cpu_err_o = err_q;
    assign cpu_dat_o = rdat_q;

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = wdat_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_cti_o = WB_CTI_CLASSIC;
    assign wbm.wbm_bte_o = WB_BTE_LINEAR;

endmodule
